// File: rtl/ex_pkg.sv
// rtl/ex_pkg.sv - shared types, instruction codes and operand-selection helpers for the EX operand stage
//
// Also carries the TYPE_*/FUNC_* instruction codes and their field widths,
// guarded so that any other definition of the same codes is not duplicated.

`ifndef EX_DEFINES_VH
`define EX_DEFINES_VH
`define W_TYPE    3
`define W_FUNC    6
`define TYPE_R    3'd0
`define TYPE_I    3'd1
`define TYPE_U    3'd2
`define TYPE_J    3'd3
`define FUNC_ADD  6'd0
`define FUNC_SLT  6'd1
`define FUNC_SLL  6'd2
`define FUNC_SRL  6'd3
`define FUNC_SRA  6'd4
`define FUNC_OR   6'd5
`define FUNC_SUB  6'd6
`endif

package ex_pkg;

  localparam int EX_DATA_W = 32;
  localparam int REG_W     = 5;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    WAIT  = 2'd1,
    VALID = 2'd2
  } state_t;

  typedef struct packed {
    logic                 valid;
    logic                 pending;
    logic [REG_W-1:0]     addr;
    logic [EX_DATA_W-1:0] data;
  } fwd_src_t;

  function automatic logic is_shift(input logic [`W_FUNC-1:0] func);
    return (func == `FUNC_SLL) || (func == `FUNC_SRL) || (func == `FUNC_SRA);
  endfunction

  // I-type arithmetic that reads rs and pairs it with the immediate.
  function automatic logic is_imm_alu(input logic [`W_TYPE-1:0] ityp,
                                      input logic [`W_FUNC-1:0] func);
    return (ityp == `TYPE_I) && ((func == `FUNC_ADD) || (func == `FUNC_SLT));
  endfunction

  // Operand A comes from rt for R-type shifts and for every non-R, non-imm-ALU case.
  function automatic logic a_is_rt(input logic [`W_TYPE-1:0] ityp,
                                   input logic [`W_FUNC-1:0] func);
    if (ityp == `TYPE_R) return is_shift(func);
    return !is_imm_alu(ityp, func);
  endfunction

  function automatic logic need_rs(input logic [`W_TYPE-1:0] ityp,
                                   input logic [`W_FUNC-1:0] func);
    return (ityp == `TYPE_R) || is_imm_alu(ityp, func);
  endfunction

  function automatic logic need_rt(input logic [`W_TYPE-1:0] ityp,
                                   input logic [`W_FUNC-1:0] func);
    return (ityp == `TYPE_R) || a_is_rt(ityp, func);
  endfunction

endpackage

// File: rtl/ex_operand_stage_if.sv
// rtl/ex_operand_stage_if.sv - issue, forwarding and ALU handshake bundle for the EX operand stage
//
// master: issue side / forwarding network / ALU (drives inputs of the stage)
// slave : the operand stage itself
//   flush                      sync drop of the held instruction
//   in_valid/in_ready          issue handshake with ityp, func, imme, rs/rt addr+data
//   fwd_valid/pending/addr/data  NUM_FWD forwarding sources, index 0 youngest
//   out_valid/out_ready        ALU handshake with source_a, source_b, stall_cnt

interface ex_operand_stage_if #(
  parameter int DATA_W  = 32,
  parameter int NUM_FWD = 3,
  parameter int CNT_W   = 4
);
  logic                             flush;
  logic                             in_valid;
  logic                             in_ready;
  logic [`W_TYPE-1:0]               ityp;
  logic [`W_FUNC-1:0]               func;
  logic [DATA_W-1:0]                imme;
  logic [4:0]                       rs_addr;
  logic [4:0]                       rt_addr;
  logic [DATA_W-1:0]                rs_data;
  logic [DATA_W-1:0]                rt_data;
  logic [NUM_FWD-1:0]               fwd_valid;
  logic [NUM_FWD-1:0]               fwd_pending;
  logic [NUM_FWD-1:0][4:0]          fwd_addr;
  logic [NUM_FWD-1:0][DATA_W-1:0]   fwd_data;
  logic                             out_valid;
  logic                             out_ready;
  logic [DATA_W-1:0]                source_a;
  logic [DATA_W-1:0]                source_b;
  logic [CNT_W-1:0]                 stall_cnt;

  modport master (
    output flush, in_valid, ityp, func, imme, rs_addr, rt_addr, rs_data, rt_data,
    output fwd_valid, fwd_pending, fwd_addr, fwd_data, out_ready,
    input  in_ready, out_valid, source_a, source_b, stall_cnt
  );

  modport slave (
    input  flush, in_valid, ityp, func, imme, rs_addr, rt_addr, rs_data, rt_data,
    input  fwd_valid, fwd_pending, fwd_addr, fwd_data, out_ready,
    output in_ready, out_valid, source_a, source_b, stall_cnt
  );
endinterface

// File: rtl/fwd_lookup.sv
// rtl/fwd_lookup.sv - priority match of one register number against the forwarding sources
//
// addr    in   register number to resolve
// src     in   NUM_FWD forwarding sources, index 0 has highest priority
// hit     out  some valid source writes addr (never for addr 0)
// pending out  the winning source has no result yet
// data    out  the winning source's result

module fwd_lookup
  import ex_pkg::*;
#(
  parameter int NUM_FWD = 3
) (
  input  logic [REG_W-1:0]            addr,
  input  fwd_src_t [NUM_FWD-1:0]      src,
  output logic                        hit,
  output logic                        pending,
  output logic [EX_DATA_W-1:0]        data
);

  // Scanning oldest to youngest lets the lowest matching index overwrite the
  // rest, so a pending young source is never bypassed by an older one.
  always_comb begin
    hit     = 1'b0;
    pending = 1'b0;
    data    = '0;
    if (addr != '0) begin
      for (int i = NUM_FWD - 1; i >= 0; i--) begin
        if (src[i].valid && (src[i].addr == addr)) begin
          hit     = 1'b1;
          pending = src[i].pending;
          data    = src[i].data;
        end
      end
    end
  end

endmodule

// File: rtl/ex_operand_stage.sv
// rtl/ex_operand_stage.sv - registered EX operand selector with forwarding and load-use hold
//
// clk     in   clock
// resetn  in   asynchronous active-low reset
// bus     slave modport of ex_operand_stage_if (issue, forwarding, ALU handshake)

module ex_operand_stage
  import ex_pkg::*;
#(
  parameter int DATA_W  = EX_DATA_W,
  parameter int NUM_FWD = 3,
  parameter int CNT_W   = 4
) (
  input  logic               clk,
  input  logic               resetn,
  ex_operand_stage_if.slave  bus
);

  state_t state_q, state_d;

  logic [`W_TYPE-1:0] ityp_q;
  logic [`W_FUNC-1:0] func_q;
  logic [DATA_W-1:0]  imme_q;
  logic [4:0]         rs_addr_q, rt_addr_q;
  logic [DATA_W-1:0]  rs_data_q, rt_data_q;
  logic [DATA_W-1:0]  rs_val_q, rt_val_q;
  logic               rs_ok_q, rt_ok_q;
  logic [CNT_W-1:0]   stall_cnt_q;

  fwd_src_t [NUM_FWD-1:0] fwd;

  logic              in_wait, in_ready, cap;
  logic [4:0]        lk_rs_addr, lk_rt_addr;
  logic [DATA_W-1:0] lk_rs_rf, lk_rt_rf;
  logic              rs_hit, rs_pend, rt_hit, rt_pend;
  logic [DATA_W-1:0] rs_fdata, rt_fdata;
  logic              rs_res_ok, rt_res_ok;
  logic [DATA_W-1:0] rs_res_val, rt_res_val;
  logic              cap_rs_ok, cap_rt_ok, cap_ok, all_ok;

  always_comb begin
    for (int i = 0; i < NUM_FWD; i++) begin
      fwd[i] = '{valid:   bus.fwd_valid[i],
                 pending: bus.fwd_pending[i],
                 addr:    bus.fwd_addr[i],
                 data:    bus.fwd_data[i]};
    end
  end

  // One lookup per operand serves both paths: WAIT re-resolves the captured
  // addresses, every other state resolves the incoming instruction.
  assign in_wait    = (state_q == WAIT);
  assign lk_rs_addr = in_wait ? rs_addr_q : bus.rs_addr;
  assign lk_rt_addr = in_wait ? rt_addr_q : bus.rt_addr;
  assign lk_rs_rf   = in_wait ? rs_data_q : bus.rs_data;
  assign lk_rt_rf   = in_wait ? rt_data_q : bus.rt_data;

  fwd_lookup #(.NUM_FWD(NUM_FWD)) u_rs_lookup (
    .addr    (lk_rs_addr),
    .src     (fwd),
    .hit     (rs_hit),
    .pending (rs_pend),
    .data    (rs_fdata)
  );

  fwd_lookup #(.NUM_FWD(NUM_FWD)) u_rt_lookup (
    .addr    (lk_rt_addr),
    .src     (fwd),
    .hit     (rt_hit),
    .pending (rt_pend),
    .data    (rt_fdata)
  );

  assign rs_res_ok  = !(rs_hit && rs_pend);
  assign rt_res_ok  = !(rt_hit && rt_pend);
  assign rs_res_val = (lk_rs_addr == '0) ? '0 : (rs_hit ? rs_fdata : lk_rs_rf);
  assign rt_res_val = (lk_rt_addr == '0) ? '0 : (rt_hit ? rt_fdata : lk_rt_rf);

  // An operand the instruction does not read is marked resolved at capture.
  assign cap_rs_ok = !need_rs(bus.ityp, bus.func) || rs_res_ok;
  assign cap_rt_ok = !need_rt(bus.ityp, bus.func) || rt_res_ok;
  assign cap_ok    = cap_rs_ok && cap_rt_ok;
  assign all_ok    = (rs_ok_q || rs_res_ok) && (rt_ok_q || rt_res_ok);

  assign in_ready = (state_q == EMPTY) || ((state_q == VALID) && bus.out_ready);
  assign cap      = bus.in_valid && in_ready && !bus.flush;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      EMPTY:   if (cap) state_d = cap_ok ? VALID : WAIT;
      WAIT:    if (all_ok) state_d = VALID;
      VALID:   if (bus.out_ready) state_d = cap ? (cap_ok ? VALID : WAIT) : EMPTY;
      default: state_d = EMPTY;
    endcase
    if (bus.flush) state_d = EMPTY;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ityp_q      <= '0;
      func_q      <= '0;
      imme_q      <= '0;
      rs_addr_q   <= '0;
      rt_addr_q   <= '0;
      rs_data_q   <= '0;
      rt_data_q   <= '0;
      rs_val_q    <= '0;
      rt_val_q    <= '0;
      rs_ok_q     <= 1'b0;
      rt_ok_q     <= 1'b0;
      stall_cnt_q <= '0;
    end else if (cap) begin
      ityp_q      <= bus.ityp;
      func_q      <= bus.func;
      imme_q      <= bus.imme;
      rs_addr_q   <= bus.rs_addr;
      rt_addr_q   <= bus.rt_addr;
      rs_data_q   <= bus.rs_data;
      rt_data_q   <= bus.rt_data;
      rs_val_q    <= rs_res_val;
      rt_val_q    <= rt_res_val;
      rs_ok_q     <= cap_rs_ok;
      rt_ok_q     <= cap_rt_ok;
      stall_cnt_q <= '0;
    end else if (in_wait && !bus.flush) begin
      // Only still-unresolved operands may latch; resolved ones are frozen.
      if (!rs_ok_q && rs_res_ok) begin
        rs_val_q <= rs_res_val;
        rs_ok_q  <= 1'b1;
      end
      if (!rt_ok_q && rt_res_ok) begin
        rt_val_q <= rt_res_val;
        rt_ok_q  <= 1'b1;
      end
      if (stall_cnt_q != '1) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end
  end

  // Operands are a pure mux of captured state, so they stay stable while held.
  always_comb begin
    bus.source_a = rs_val_q;
    bus.source_b = rt_val_q;
    if (ityp_q == `TYPE_R) begin
      if (is_shift(func_q)) begin
        bus.source_a = rt_val_q;
        bus.source_b = rs_val_q;
      end
    end else begin
      bus.source_a = a_is_rt(ityp_q, func_q) ? rt_val_q : rs_val_q;
      bus.source_b = imme_q;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = (state_q == VALID);
  assign bus.stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_ex_operand_stage.sv
// tb/tb_ex_operand_stage.sv - scoreboard bench for ex_operand_stage

`ifndef EX_DEFINES_VH
`define EX_DEFINES_VH
`define W_TYPE    3
`define W_FUNC    6
`define TYPE_R    3'd0
`define TYPE_I    3'd1
`define TYPE_U    3'd2
`define TYPE_J    3'd3
`define FUNC_ADD  6'd0
`define FUNC_SLT  6'd1
`define FUNC_SLL  6'd2
`define FUNC_SRL  6'd3
`define FUNC_SRA  6'd4
`define FUNC_OR   6'd5
`define FUNC_SUB  6'd6
`endif

module tb_ex_operand_stage;

  localparam int DATA_W  = 32;
  localparam int NUM_FWD = 3;
  localparam int CNT_W   = 4;

  logic clk    = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  ex_operand_stage_if #(.DATA_W(DATA_W), .NUM_FWD(NUM_FWD), .CNT_W(CNT_W)) bus ();

  ex_operand_stage #(.DATA_W(DATA_W), .NUM_FWD(NUM_FWD), .CNT_W(CNT_W)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  cnt;
  } exp_t;

  exp_t q[$];
  int n_checks = 0;
  int n_fail   = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  // Monitor: every presented output is compared against the queue head; it is
  // only retired on the handshake, so a held output is re-checked each cycle.
  always @(negedge clk) begin
    if (resetn && bus.out_valid) begin
      if (q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_output: got a=0x%0h b=0x%0h, expected no output",
                 bus.source_a, bus.source_b);
      end else begin
        check("source_a", bus.source_a, q[0].a);
        check("source_b", bus.source_b, q[0].b);
        check("stall_cnt", 32'(bus.stall_cnt), 32'(q[0].cnt));
        if (bus.out_ready) q.delete(0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_fwd(input int i, input logic v, input logic p,
                         input logic [4:0] a, input logic [31:0] d);
    bus.fwd_valid[i]   = v;
    bus.fwd_pending[i] = p;
    bus.fwd_addr[i]    = a;
    bus.fwd_data[i]    = d;
  endtask

  task automatic clear_fwd();
    bus.fwd_valid   = '0;
    bus.fwd_pending = '0;
    bus.fwd_addr    = '0;
    bus.fwd_data    = '0;
  endtask

  task automatic drive(input logic [`W_TYPE-1:0] t, input logic [`W_FUNC-1:0] f,
                       input logic [31:0] imm, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [31:0] rsd, input logic [31:0] rtd);
    bus.ityp     = t;
    bus.func     = f;
    bus.imme     = imm;
    bus.rs_addr  = rs;
    bus.rt_addr  = rt;
    bus.rs_data  = rsd;
    bus.rt_data  = rtd;
    bus.in_valid = 1'b1;
  endtask

  // Called just after a rising edge; returns just after the capturing edge.
  task automatic issue(input logic [`W_TYPE-1:0] t, input logic [`W_FUNC-1:0] f,
                       input logic [31:0] imm, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [31:0] rsd, input logic [31:0] rtd,
                       input bit push, input logic [31:0] ea, input logic [31:0] eb,
                       input logic [3:0] ec);
    bit accepted;
    accepted = 0;
    if (push) q.push_back('{a: ea, b: eb, cnt: ec});
    drive(t, f, imm, rs, rt, rsd, rtd);
    for (int k = 0; k < 50 && !accepted; k++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        @(posedge clk);
        #1;
        accepted = 1;
      end
    end
    bus.in_valid = 1'b0;
    if (!accepted) begin
      n_checks++;
      n_fail++;
      $display("FAIL issue_timeout: in_ready stayed 0, expected acceptance within 50 cycles");
    end
  endtask

  task automatic expect_ov(input string name, input logic exp);
    @(negedge clk);
    check(name, 32'(bus.out_valid), 32'(exp));
  endtask

  initial begin
    bus.flush     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    drive(`TYPE_R, `FUNC_ADD, 0, 0, 0, 0, 0);
    bus.in_valid  = 1'b0;
    clear_fwd();

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_out_valid", 32'(bus.out_valid), 0);
    check("rst_source_a", bus.source_a, 0);
    check("rst_source_b", bus.source_b, 0);
    check("rst_stall_cnt", 32'(bus.stall_cnt), 0);
    resetn = 1'b1;
    @(negedge clk);
    check("rst_in_ready", 32'(bus.in_ready), 1);
    tick();

    // No hazard R-type ADD: a=rs, b=rt, one-cycle latency
    issue(`TYPE_R, `FUNC_ADD, 0, 3, 4, 5, 7, 1, 5, 7, 0);
    expect_ov("add_latency", 1);
    tick();

    // SLL: swapped operands, rt from fwd[1]; then fwd[0] outranks fwd[1]
    set_fwd(1, 1, 0, 5, 32'h20);
    issue(`TYPE_R, `FUNC_SLL, 0, 2, 5, 4, 32'h10, 1, 32'h20, 4, 0);
    expect_ov("sll_fwd1", 1);
    tick();
    set_fwd(0, 1, 0, 5, 32'h30);
    issue(`TYPE_R, `FUNC_SLL, 0, 2, 5, 4, 32'h10, 1, 32'h30, 4, 0);
    expect_ov("sll_fwd0_prio", 1);
    tick();
    clear_fwd();

    // Load-use: young pending source must not fall through to fwd[1]
    set_fwd(0, 1, 1, 6, 0);
    set_fwd(1, 1, 0, 6, 32'h66);
    issue(`TYPE_I, `FUNC_ADD, 1, 6, 8, 6, 32'h55, 1, 9, 1, 2);
    expect_ov("lu_wait1", 0);
    check("lu_in_ready", 32'(bus.in_ready), 0);
    tick();
    set_fwd(0, 1, 0, 6, 9);
    expect_ov("lu_wait2", 0);
    expect_ov("lu_resolved", 1);
    tick();
    clear_fwd();

    // Resolved rs is not overwritten by a later forward while rt waits
    set_fwd(0, 1, 1, 14, 0);
    issue(`TYPE_R, `FUNC_ADD, 0, 13, 14, 32'h13, 32'h1400, 1, 32'h13, 32'h14, 2);
    set_fwd(1, 1, 0, 13, 32'hBAD);
    expect_ov("hold_wait1", 0);
    tick();
    set_fwd(0, 1, 0, 14, 32'h14);
    expect_ov("hold_wait2", 0);
    expect_ov("hold_resolved", 1);
    tick();
    clear_fwd();

    // ORI: a=rt is needed and pending -> one WAIT cycle
    set_fwd(0, 1, 1, 7, 0);
    issue(`TYPE_I, `FUNC_OR, 32'hF0, 1, 7, 32'h11, 32'h99, 1, 32'h77, 32'hF0, 1);
    set_fwd(0, 1, 0, 7, 32'h77);
    expect_ov("ori_stall", 0);
    expect_ov("ori_resolved", 1);
    tick();
    clear_fwd();

    // LUI-type: only rs pending, rs unneeded -> no stall
    set_fwd(0, 1, 1, 9, 0);
    issue(`TYPE_U, `FUNC_ADD, 32'h5000, 9, 10, 32'h99, 32'h1234, 1, 32'h1234, 32'h5000, 0);
    expect_ov("lui_nostall", 1);
    tick();
    clear_fwd();

    // $0 resolves to 0 despite pending and non-pending forward matches
    set_fwd(0, 1, 1, 0, 0);
    set_fwd(1, 1, 0, 0, 32'hBEEF);
    issue(`TYPE_R, `FUNC_ADD, 0, 0, 11, 32'hDEAD, 32'h42, 1, 0, 32'h42, 0);
    expect_ov("zero_reg", 1);
    tick();
    clear_fwd();

    // stall_cnt saturates at 15 over 20 WAIT cycles
    set_fwd(0, 1, 1, 6, 0);
    issue(`TYPE_I, `FUNC_SLT, 3, 6, 0, 0, 0, 1, 32'h21, 3, 15);
    repeat (19) tick();
    set_fwd(0, 1, 0, 6, 32'h21);
    expect_ov("sat_wait", 0);
    expect_ov("sat_resolved", 1);
    tick();
    clear_fwd();

    // Back-to-back: in_valid held, out_ready 1,0,1,1 across VALID cycles
    q.push_back('{a: 32'h101, b: 32'h102, cnt: 0});
    q.push_back('{a: 32'h201, b: 32'h202, cnt: 0});
    q.push_back('{a: 32'h301, b: 32'h302, cnt: 0});
    q.push_back('{a: 32'h401, b: 32'h402, cnt: 0});
    drive(`TYPE_R, `FUNC_ADD, 0, 1, 2, 32'h101, 32'h102);
    tick();
    drive(`TYPE_R, `FUNC_ADD, 0, 1, 2, 32'h201, 32'h202);
    bus.out_ready = 1'b1;
    tick();
    drive(`TYPE_R, `FUNC_ADD, 0, 1, 2, 32'h301, 32'h302);
    bus.out_ready = 1'b0;
    @(negedge clk);
    check("b2b_in_ready_low", 32'(bus.in_ready), 0);
    tick();
    bus.out_ready = 1'b1;
    tick();
    drive(`TYPE_R, `FUNC_ADD, 0, 1, 2, 32'h401, 32'h402);
    tick();
    bus.in_valid = 1'b0;
    tick();
    check("b2b_all_retired", 32'(q.size()), 0);

    // flush in WAIT with a simultaneous in_valid: no capture
    set_fwd(0, 1, 1, 6, 0);
    issue(`TYPE_I, `FUNC_ADD, 1, 6, 0, 0, 0, 0, 0, 0, 0);
    drive(`TYPE_R, `FUNC_ADD, 0, 1, 2, 32'hAA, 32'hBB);
    bus.flush = 1'b1;
    tick();
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    clear_fwd();
    expect_ov("flush_out_valid", 0);
    check("flush_in_ready", 32'(bus.in_ready), 1);
    expect_ov("flush_no_capture", 0);
    tick();

    // resetn pulsed while VALID: outputs return to reset values at once
    bus.out_ready = 1'b0;
    issue(`TYPE_R, `FUNC_ADD, 0, 3, 4, 5, 7, 1, 5, 7, 0);
    expect_ov("prerst_valid", 1);
    #2;
    resetn = 1'b0;
    #1;
    check("midrst_out_valid", 32'(bus.out_valid), 0);
    check("midrst_source_a", bus.source_a, 0);
    check("midrst_source_b", bus.source_b, 0);
    check("midrst_stall_cnt", 32'(bus.stall_cnt), 0);
    q.delete();
    tick();
    resetn = 1'b1;
    bus.out_ready = 1'b1;
    tick();

    // Recovery with an R-type SRA (swapped regfile operands)
    issue(`TYPE_R, `FUNC_SRA, 0, 3, 4, 5, 7, 1, 7, 5, 0);
    expect_ov("sra_after_reset", 1);
    tick();
    tick();
    check("final_queue_empty", 32'(q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
